// File: rtl/mjpeg_unfold_pkg.sv
// Shared constants and types for the MJPEG 8x8 tile unfold DMA.
package mjpeg_unfold_pkg;

  // Register index as decoded from addr[4:2].
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SRC    = 3'd1;
  localparam logic [2:0] REG_DST    = 3'd2;
  localparam logic [2:0] REG_STRIDE = 3'd3;
  localparam logic [2:0] REG_NTILES = 3'd4;

  // CTRL write bits.
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  // CTRL read bits.
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;

  localparam int TILE_ROWS  = 8;
  localparam int TILE_BYTES = 64;
  localparam int ROW_BYTES  = TILE_BYTES / TILE_ROWS;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WT,
    WR,
    WR_WT
  } state_t;

endpackage

// File: rtl/mjpeg_unfold_regs.sv
// CPU slave: register file, start/clear decoding and busy/done status.
module mjpeg_unfold_regs
  import mjpeg_unfold_pkg::*;
#(
  parameter int NTILE_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               valid,
  input  logic [31:0]        addr,
  input  logic [3:0]         wstrb,
  input  logic [31:0]        wdata,
  input  logic               xfer_done,
  output logic               ready,
  output logic [31:0]        rdata,
  output logic [31:0]        src,
  output logic [31:0]        dst,
  output logic [15:0]        stride,
  output logic [NTILE_W-1:0] ntiles,
  output logic               start
);

  logic        busy;
  logic        done;
  logic        access;
  logic        wr;
  logic        ctrl_wr;
  logic        start_empty;
  logic        clear;
  logic [2:0]  idx;
  logic [31:0] rd_mux;
  logic        addr_unused;

  assign idx         = addr[4:2];
  assign addr_unused = ^{addr[31:5], addr[1:0]};

  // A request is taken once; ready blocks re-acceptance in the ack cycle.
  assign access      = valid && en && !ready;
  assign wr          = access && (wstrb != 4'b0000);
  assign ctrl_wr     = wr && (idx == REG_CTRL);
  // Start is combinational so the engine launches at the accepting edge.
  assign start       = ctrl_wr && wdata[CTRL_START] && !busy && (ntiles != '0);
  assign start_empty = ctrl_wr && wdata[CTRL_START] && !busy && (ntiles == '0);
  assign clear       = ctrl_wr && wdata[CTRL_CLEAR];

  // Read-data selection from pre-edge register values.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_CTRL:   rd_mux = {30'b0, done, busy};
      REG_SRC:    rd_mux = src;
      REG_DST:    rd_mux = dst;
      REG_STRIDE: rd_mux = {16'b0, stride};
      REG_NTILES: rd_mux = {{(32 - NTILE_W){1'b0}}, ntiles};
      default:    rd_mux = '0;
    endcase
  end

  // Bus handshake, register writes and busy/done status.
  // NOTE: clocked state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready  <= 1'b0;
      rdata  <= '0;
      src    <= '0;
      dst    <= '0;
      stride <= '0;
      ntiles <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ready <= access;
      if (access) rdata <= rd_mux;

      if (wr && !busy) begin
        case (idx)
          REG_SRC:    src    <= {wdata[31:2], 2'b00};
          REG_DST:    dst    <= {wdata[31:2], 2'b00};
          REG_STRIDE: stride <= {wdata[15:2], 2'b00};
          REG_NTILES: ntiles <= wdata[NTILE_W-1:0];
          default:    ;
        endcase
      end

      if (xfer_done)  busy <= 1'b0;
      else if (start) busy <= 1'b1;

      // Completion beats a same-edge clear.
      if (xfer_done || start_empty) done <= 1'b1;
      else if (start || clear)      done <= 1'b0;
    end
  end

endmodule

// File: rtl/mjpeg_unfold_dma.sv
// Tile unfold DMA: copies N horizontally adjacent 8x8 tiles into 64-byte blocks.
module mjpeg_unfold_dma
  import mjpeg_unfold_pkg::*;
#(
  parameter int NTILE_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        valid,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  logic [31:0]        src;
  logic [31:0]        dst;
  logic [15:0]        stride;
  logic [NTILE_W-1:0] ntiles;
  logic               start;
  logic               last_ack;

  state_t             state;
  logic [2:0]         row;
  logic               word;
  logic [NTILE_W-1:0] tile;
  logic [31:0]        rd_tile;  // src + 8n
  logic [31:0]        rd_row;   // src + 8n + r*stride
  logic [31:0]        wr_ptr;   // dst + 64n + 8r, advances 8 bytes per row
  logic [31:0]        data_buf [2];
  logic [31:0]        stride_ext;

  assign stride_ext = {16'b0, stride};

  assign last_ack = (state == WR_WT) && mem_ready && word &&
                    (row == 3'(TILE_ROWS - 1)) &&
                    (tile == ntiles - NTILE_W'(1));

  mjpeg_unfold_regs #(
    .NTILE_W (NTILE_W)
  ) u_regs (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .valid     (valid),
    .addr      (addr),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .xfer_done (last_ack),
    .ready     (ready),
    .rdata     (rdata),
    .src       (src),
    .dst       (dst),
    .stride    (stride),
    .ntiles    (ntiles),
    .start     (start)
  );

  // Capture each read word of the current row into the two-word buffer.
  // NOTE: the buffer has no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (state == RD_WT && mem_ready) data_buf[word] <= mem_rdata;
  end

  // Transfer FSM with registered memory-port outputs and address pointers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      row       <= '0;
      word      <= 1'b0;
      tile      <= '0;
      rd_tile   <= '0;
      rd_row    <= '0;
      wr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD;
            mem_valid <= 1'b1;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            mem_addr  <= src;
            rd_tile   <= src;
            rd_row    <= src;
            wr_ptr    <= dst;
            row       <= '0;
            word      <= 1'b0;
            tile      <= '0;
          end
        end
        RD: begin
          mem_valid <= 1'b0;
          state     <= RD_WT;
        end
        RD_WT: begin
          if (mem_ready) begin
            mem_valid <= 1'b1;
            if (!word) begin
              word     <= 1'b1;
              mem_addr <= rd_row + 32'd4;
              state    <= RD;
            end else begin
              word      <= 1'b0;
              mem_write <= 1'b1;
              mem_addr  <= wr_ptr;
              mem_wdata <= data_buf[0];
              state     <= WR;
            end
          end
        end
        WR: begin
          mem_valid <= 1'b0;
          mem_write <= 1'b0;
          mem_wdata <= '0;
          state     <= WR_WT;
        end
        WR_WT: begin
          if (mem_ready) begin
            if (!word) begin
              word      <= 1'b1;
              mem_valid <= 1'b1;
              mem_write <= 1'b1;
              mem_addr  <= wr_ptr + 32'd4;
              mem_wdata <= data_buf[1];
              state     <= WR;
            end else if (last_ack) begin
              word  <= 1'b0;
              state <= IDLE;
            end else begin
              word      <= 1'b0;
              mem_valid <= 1'b1;
              wr_ptr    <= wr_ptr + 32'(ROW_BYTES);
              state     <= RD;
              if (row == 3'(TILE_ROWS - 1)) begin
                row      <= '0;
                tile     <= tile + NTILE_W'(1);
                rd_tile  <= rd_tile + 32'(ROW_BYTES);
                rd_row   <= rd_tile + 32'(ROW_BYTES);
                mem_addr <= rd_tile + 32'(ROW_BYTES);
              end else begin
                row      <= row + 3'd1;
                rd_row   <= rd_row + stride_ext;
                mem_addr <= rd_row + stride_ext;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mjpeg_unfold_dma.sv
// Self-checking bench: register vector table, directed transfers and random
// transfers compared against a byte-level tile-unfold reference.
module tb_mjpeg_unfold_dma;

  localparam logic [31:0] BASE     = 32'h4000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_SRC    = BASE + 32'h04;
  localparam logic [31:0] A_DST    = BASE + 32'h08;
  localparam logic [31:0] A_STRIDE = BASE + 32'h0C;
  localparam logic [31:0] A_NTILES = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_edge = 0;

  mjpeg_unfold_dma #(.NTILE_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .valid     (valid),
    .addr      (addr),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata),
    .mem_valid (mem_valid),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  typedef struct { bit w; logic [31:0] a; logic [31:0] d; } acc_t;
  acc_t        log_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_rd = 0, n_wr = 0, n_dbl = 0, n_badw = 0;
  logic        prev_valid = 1'b0;
  logic        wipe = 1'b0;

  function automatic logic [7:0] pat_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [31:0] pat_word(input logic [31:0] a);
    return {pat_byte(a + 3), pat_byte(a + 2), pat_byte(a + 1), pat_byte(a)};
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat_word(a);
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = rd_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (wipe) mem.delete();
    if (mem_valid) begin
      if (prev_valid) n_dbl = n_dbl + 1;
      mem_ready <= 1'b1;
      if (mem_write) begin
        mem[mem_addr] = mem_wdata;
        n_wr = n_wr + 1;
        log_q.push_back('{1'b1, mem_addr, mem_wdata});
      end else begin
        mem_rdata <= rd_word(mem_addr);
        n_rd = n_rd + 1;
        if (mem_wdata != 32'h0) n_badw = n_badw + 1;
        log_q.push_back('{1'b0, mem_addr, rd_word(mem_addr)});
      end
    end
    prev_valid <= mem_valid;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] q, output logic rdy_after);
    bit got;
    got = 0;
    valid = 1'b1; en = 1'b1; addr = a; wdata = d; wstrb = w ? 4'hF : 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) begin got = 1; break; end
    end
    q = rdata;
    last_edge = cyc;
    valid = 1'b0; wstrb = 4'h0;
    if (!got) check("bus_timeout", 0, 1);
    @(negedge clk);
    rdy_after = ready;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q; logic r;
    bus(1'b1, a, d, q, r);
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] q; logic r;
    bus(1'b0, a, 32'h0, q, r);
    check(name, q, exp);
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 20000 && cyc < target; i++) @(negedge clk);
  endtask

  task automatic prog(input logic [31:0] s, input logic [31:0] d,
                      input logic [31:0] st, input int nt);
    wr32(A_SRC, s); wr32(A_DST, d); wr32(A_STRIDE, st); wr32(A_NTILES, nt);
  endtask

  int base_rd, base_wr, base_dbl, base_badw, base_log;

  task automatic start_xfer(output int t);
    wipe = 1'b1;
    @(negedge clk);
    wipe = 1'b0;
    base_rd = n_rd; base_wr = n_wr; base_dbl = n_dbl; base_badw = n_badw;
    base_log = log_q.size();
    wr32(A_CTRL, 32'h1);
    t = last_edge;
  endtask

  // late=0: probe at the completion edge (still busy); late=1: one edge after (done).
  task automatic finish_xfer(input string tag, input int t, input int nt, input bit late);
    int e;
    e = t + 64 * nt;
    if (!late) begin
      wait_until(e - 1);
      check({tag, "_probe_align"}, cyc, e - 1);
      rd_check({tag, "_ctrl_at_end"}, A_CTRL, 32'h1);
      rd_check({tag, "_ctrl_done"}, A_CTRL, 32'h2);
    end else begin
      wait_until(e);
      check({tag, "_probe_align"}, cyc, e);
      rd_check({tag, "_ctrl_after_end"}, A_CTRL, 32'h2);
    end
  endtask

  // Reference: byte b of unfolded tile n is source row b/8, column b%8 of tile n.
  task automatic verify(input string tag, input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] st, input int nt);
    logic [63:0] exp_row, act_row;
    logic [31:0] sa, da;
    for (int n = 0; n < nt; n++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          sa = s + 32'(8 * n) + 32'(r) * st + 32'(c);
          da = d + 32'(64 * n) + 32'(8 * r + c);
          exp_row[8*c +: 8] = pat_byte(sa);
          act_row[8*c +: 8] = mem_byte(da);
        end
        check($sformatf("%s_t%0d_r%0d", tag, n, r), act_row, exp_row);
      end
    end
    check({tag, "_reads"},  n_rd - base_rd, 16 * nt);
    check({tag, "_writes"}, n_wr - base_wr, 16 * nt);
    check({tag, "_valid_1cyc"}, n_dbl - base_dbl, 0);
    check({tag, "_rd_wdata0"}, n_badw - base_badw, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t        v;
    logic [31:0] q;
    logic        r;
    logic        saw;
    int          t;
    logic [31:0] s, d, st;
    int          nt;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Register vector table.
    vecs.push_back('{0, A_CTRL,   32'h0,         32'h0,     "ctrl_reset"});
    vecs.push_back('{0, A_SRC,    32'h0,         32'h0,     "src_reset"});
    vecs.push_back('{1, A_SRC,    32'h0001_0001, 32'h0,     "src_wr"});
    vecs.push_back('{0, A_SRC,    32'h0,         32'h10000, "src_rd"});
    vecs.push_back('{1, A_DST,    32'h0002_0003, 32'h0,     "dst_wr"});
    vecs.push_back('{0, A_DST,    32'h0,         32'h20000, "dst_rd"});
    vecs.push_back('{1, A_STRIDE, 32'hFFFF_0013, 32'h0,     "stride_wr"});
    vecs.push_back('{0, A_STRIDE, 32'h0,         32'h10,    "stride_rd"});
    vecs.push_back('{1, A_NTILES, 32'h0000_01FF, 32'h0,     "ntiles_wr"});
    vecs.push_back('{0, A_NTILES, 32'h0,         32'hFF,    "ntiles_rd"});
    vecs.push_back('{0, BASE + 32'h1C, 32'h0,    32'h0,     "off1c_rd"});
    vecs.push_back('{1, BASE + 32'h14, 32'hDEAD, 32'h0,     "off14_wr"});
    vecs.push_back('{0, BASE + 32'h14, 32'h0,    32'h0,     "off14_rd"});
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      bus(v.wr, v.a, v.d, q, r);
      if (!v.wr) check(v.name, q, v.exp);
      check({v.name, "_ready_1cyc"}, r, 0);
    end

    // Requests outside the window are not acknowledged.
    saw = 0;
    valid = 1'b1; en = 1'b0; addr = A_SRC; wstrb = 4'h0;
    repeat (4) begin @(negedge clk); saw = saw | ready; end
    valid = 1'b0; en = 1'b1;
    @(negedge clk);
    check("en_gate", saw, 0);

    // Single tile.
    prog(32'h10000, 32'h20000, 32'd8, 1);
    start_xfer(t);
    finish_xfer("single", t, 1, 0);
    verify("single", 32'h10000, 32'h20000, 32'd8, 1);

    // Strided three-tile image.
    prog(32'h10000, 32'h20000, 32'd24, 3);
    start_xfer(t);
    finish_xfer("strided", t, 3, 1);
    verify("strided", 32'h10000, 32'h20000, 32'd24, 3);
    check("strided_log_len", log_q.size() > base_log + 42, 1);
    if (log_q.size() > base_log + 42) begin
      check("t1r2_rd_is_read", log_q[base_log + 40].w, 0);
      check("t1r2_rd_addr", log_q[base_log + 40].a, 32'h10000 + 8 + 48);
      check("t1r2_wr_is_write", log_q[base_log + 42].w, 1);
      check("t1r2_wr_addr", log_q[base_log + 42].a, 32'h20000 + 64 + 16);
      check("t1r2_wr_data", log_q[base_log + 42].d, pat_word(32'h10038));
    end

    // Busy protection: SRC write and restart during a transfer are ignored.
    prog(32'h10100, 32'h21000, 32'd16, 2);
    start_xfer(t);
    wait_until(t + 20);
    wr32(A_SRC, 32'h1_8000);
    wr32(A_CTRL, 32'h1);
    finish_xfer("busy", t, 2, 1);
    verify("busy", 32'h10100, 32'h21000, 32'd16, 2);
    rd_check("busy_src_kept", A_SRC, 32'h10100);

    // NTILES = 0: done without any memory traffic, then clear done.
    prog(32'h10000, 32'h20000, 32'd8, 0);
    start_xfer(t);
    rd_check("nt0_ctrl", A_CTRL, 32'h2);
    check("nt0_no_traffic", (n_rd - base_rd) + (n_wr - base_wr), 0);
    wr32(A_CTRL, 32'h2);
    rd_check("nt0_cleared", A_CTRL, 32'h0);

    // Reset 30 cycles into a tile, then a fresh transfer.
    prog(32'h10000, 32'h22000, 32'd8, 1);
    start_xfer(t);
    wait_until(t + 29);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_mem_valid", mem_valid, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_mem_valid_after", mem_valid, 0);
    rd_check("midrst_ctrl", A_CTRL, 32'h0);
    rd_check("midrst_src", A_SRC, 32'h0);
    prog(32'h10200, 32'h22000, 32'd8, 1);
    start_xfer(t);
    finish_xfer("post_rst", t, 1, 0);
    verify("post_rst", 32'h10200, 32'h22000, 32'd8, 1);

    // Address wrap past 2^32 on both source and destination.
    prog(32'hFFFF_FF00, 32'hFFFF_FFE0, 32'h40, 1);
    start_xfer(t);
    finish_xfer("wrap", t, 1, 1);
    verify("wrap", 32'hFFFF_FF00, 32'hFFFF_FFE0, 32'h40, 1);

    // Randomized transfers.
    for (int k = 0; k < 5; k++) begin
      s  = 32'h10000 + ($urandom_range(0, 1023) << 2);
      d  = 32'h30000 + ($urandom_range(0, 255) << 2);
      st = $urandom_range(2, 40) << 2;
      nt = $urandom_range(1, 4);
      prog(s, d, st, nt);
      start_xfer(t);
      finish_xfer($sformatf("rnd%0d", k), t, nt, k[0]);
      verify($sformatf("rnd%0d", k), s, d, st, nt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
